hazard_forward_unit: RTL and testbench
======================================

Name: hazard_forward_unit

Overview:
Parametrised hazard and forwarding controller for the pipelined MIPS core. It sits beside the ID stage and keeps its own tag pipeline recording the destination register of every in-flight instruction over DEPTH downstream stages. Each cycle it selects a forwarding source for each of NSRC operand reads. It raises a stall when a source depends on a load whose data is not yet available. It generalises the fixed two-stage, two-operand forwarding logic to any depth and operand count, with youngest-producer priority, load-use stall, flush handling and a stall counter.

Parameters:
AW, 5, register address width
NSRC, 2, number of source operands checked per ID instruction
DEPTH, 3, tracked stages after ID (stage 0 = EX, 1 = MEM, 2 = WB)
LOAD_READY, 1, first stage index whose load result can be forwarded
SW, $clog2(DEPTH+1), forward-select width per source (derived, not overridden)

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
id_valid  in  1  ID stage holds a real instruction
id_rd  in  AW  ID destination register
id_we  in  1  ID instruction writes the register file
id_is_load  in  1  ID instruction is a load (lw/lh/lb...)
id_src  in  NSRC*AW  source register addresses; source j at bits [j*AW +: AW]
id_src_used  in  NSRC  source j is actually read (e.g. 0 for the rt field of an immediate-form instruction, 0 for jumps)
flush  in  1  kill the ID instruction (taken branch/jump)
fwd_sel  out  NSRC*SW  per source: 0 = register file, k = forward from stage k-1
stall  out  1  hold PC and IF/ID; insert a bubble into EX
stall_count  out  32  saturating count of stalled cycles

Behaviour:
- Tag pipeline: DEPTH entries t[i] = {v, rd, we, ld}.
- An entry is a producer when v & we & rd != 0.
- Reset (rst=1 at posedge): all t[i].v = 0 and stall_count = 0. Consequently fwd_sel = 0 and stall = 0 from the first cycle after reset. Reset mid-operation discards all tags.
- Clock update, in priority order:
  - rst: as above.
  - flush: t[0] <= bubble (v=0); t[i] <= t[i-1] for i>=1.
  - stall: same as flush; the bubble goes into EX while the ID instruction is held.
  - otherwise: t[0] <= {id_valid, id_rd, id_we, id_is_load}; t[i] <= t[i-1].
  - Entries shifting out of t[DEPTH-1] are dropped; the register file now holds their result.
- Forwarding (combinational, same cycle):
  - Source j is ignored (sel = 0, no hazard) when id_src_used[j] = 0 or its address is 0.
  - Otherwise k = the smallest index with a producer whose rd equals the source. The youngest producer wins; older matches are ignored.
  - No match: sel = 0.
  - Match with t[k].ld = 1 and k < LOAD_READY: hazard_j = 1 and sel = 0.
  - Otherwise: sel = k+1.
- stall = id_valid & !flush & OR(hazard_j). flush overrides stall.
- A stall lasts exactly until the load reaches stage LOAD_READY. With the defaults that is 1 cycle; with LOAD_READY = 2 it is 2 cycles. No deadlock is possible, because the load always advances.
- stall_count increments on every clock with stall = 1 and rst = 0, and saturates at 0xFFFF_FFFF.
- fwd_sel is valid even when stall = 1. Consumers ignore it during a stall.
- No internal latency on outputs. Tag state updates one clock after ID inputs are sampled.

Test Plan:
1. Back-to-back ALU dependency, defaults: add $3 then sub $4,$3,$5 -> on the cycle sub is in ID, fwd_sel[src0] = 1, stall = 0.
2. Priority: add $3; add $3; or $6,$3,$3 -> both sources sel = 1 (youngest), not 2. When the first add is alone in t[2], sel = 3.
3. Load-use: lw $2 then add $7,$2,$1 -> stall = 1 for exactly 1 cycle, EX receives a bubble, then fwd_sel[src0] = 2 and stall_count = 1. With LOAD_READY = 2: stall for 2 cycles and stall_count = 2.
4. Ignored sources: write to $0 followed by a read of $0, or addi with id_src_used = 2'b01 while rt matches a producer -> fwd_sel = 0 for that source, stall = 0.
5. Flush during hazard: lw $2, then ID holds add $8,$2,$2 with flush = 1 -> stall = 0; next cycle t[0].v = 0 and stall_count is unchanged.
6. Reset mid-stream: assert rst during a load-use stall -> next cycle stall = 0, all fwd_sel = 0, stall_count = 0. Also instantiate NSRC = 3, DEPTH = 4 and repeat scenario 2 with a match at stage 3 -> sel = 4.

Source files
------------

// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand forwarding for the pipelined MIPS core.
// A tag pipeline shadows the DEPTH stages after ID and picks the youngest producer per source.
module hazard_forward_unit #(
  parameter int AW         = 5,
  parameter int NSRC       = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 1,
  localparam int SW        = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [AW-1:0]       id_rd,
  input  logic                id_we,
  input  logic                id_is_load,
  input  logic [NSRC*AW-1:0]  id_src,
  input  logic [NSRC-1:0]     id_src_used,
  input  logic                flush,
  output logic [NSRC*SW-1:0]  fwd_sel,
  output logic                stall,
  output logic [31:0]         stall_count
);

  logic [DEPTH-1:0] tag_v;
  logic [DEPTH-1:0] tag_we;
  logic [DEPTH-1:0] tag_ld;
  logic [AW-1:0]    tag_rd [DEPTH];
  logic [DEPTH-1:0] producer;
  logic [NSRC-1:0]  hazard;

  always_comb begin
    producer = '0;
    for (int i = 0; i < DEPTH; i++) begin
      producer[i] = tag_v[i] & tag_we[i] & (tag_rd[i] != '0);
    end
  end

  // Ascending scan with a found flag: the youngest matching producer wins.
  for (genvar j = 0; j < NSRC; j++) begin : g_src
    logic [AW-1:0] src;
    logic [SW-1:0] sel;
    logic          haz;
    logic          found;

    assign src = id_src[j*AW +: AW];

    always_comb begin
      sel   = '0;
      haz   = 1'b0;
      found = 1'b0;
      if (id_src_used[j] && (src != '0)) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (!found && producer[i] && (tag_rd[i] == src)) begin
            found = 1'b1;
            if (tag_ld[i] && (i < LOAD_READY)) haz = 1'b1;
            else sel = SW'(i + 1);
          end
        end
      end
    end

    assign fwd_sel[j*SW +: SW] = sel;
    assign hazard[j]           = haz;
  end

  assign stall = id_valid & ~flush & (|hazard);

  // A flushed or stalled ID instruction enters EX as a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v  <= '0;
      tag_we <= '0;
      tag_ld <= '0;
      for (int i = 0; i < DEPTH; i++) tag_rd[i] <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_we[i] <= tag_we[i-1];
        tag_ld[i] <= tag_ld[i-1];
        tag_rd[i] <= tag_rd[i-1];
      end
      if (flush || stall) begin
        tag_v[0]  <= 1'b0;
        tag_we[0] <= 1'b0;
        tag_ld[0] <= 1'b0;
        tag_rd[0] <= '0;
      end else begin
        tag_v[0]  <= id_valid;
        tag_we[0] <= id_we;
        tag_ld[0] <= id_is_load;
        tag_rd[0] <= id_rd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if (stall && (stall_count != 32'hFFFF_FFFF)) begin
      stall_count <= stall_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: default config, LOAD_READY=2 and NSRC=3/DEPTH=4 instances.
module tb_hazard_forward_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Instance a: defaults
  logic        a_rst, a_valid, a_we, a_ld, a_flush, a_stall;
  logic [4:0]  a_rd;
  logic [9:0]  a_src;
  logic [1:0]  a_used;
  logic [3:0]  a_sel;
  logic [31:0] a_cnt;

  hazard_forward_unit dut_a (
    .clk(clk), .rst(a_rst), .id_valid(a_valid), .id_rd(a_rd), .id_we(a_we),
    .id_is_load(a_ld), .id_src(a_src), .id_src_used(a_used), .flush(a_flush),
    .fwd_sel(a_sel), .stall(a_stall), .stall_count(a_cnt)
  );

  // Instance b: load data forwardable only from WB
  logic        b_rst, b_valid, b_we, b_ld, b_flush, b_stall;
  logic [4:0]  b_rd;
  logic [9:0]  b_src;
  logic [1:0]  b_used;
  logic [3:0]  b_sel;
  logic [31:0] b_cnt;

  hazard_forward_unit #(.LOAD_READY(2)) dut_b (
    .clk(clk), .rst(b_rst), .id_valid(b_valid), .id_rd(b_rd), .id_we(b_we),
    .id_is_load(b_ld), .id_src(b_src), .id_src_used(b_used), .flush(b_flush),
    .fwd_sel(b_sel), .stall(b_stall), .stall_count(b_cnt)
  );

  // Instance c: three sources, four tracked stages (SW = 3)
  logic        c_rst, c_valid, c_we, c_ld, c_flush, c_stall;
  logic [4:0]  c_rd;
  logic [14:0] c_src;
  logic [2:0]  c_used;
  logic [8:0]  c_sel;
  logic [31:0] c_cnt;

  hazard_forward_unit #(.NSRC(3), .DEPTH(4)) dut_c (
    .clk(clk), .rst(c_rst), .id_valid(c_valid), .id_rd(c_rd), .id_we(c_we),
    .id_is_load(c_ld), .id_src(c_src), .id_src_used(c_used), .flush(c_flush),
    .fwd_sel(c_sel), .stall(c_stall), .stall_count(c_cnt)
  );

  // Each drive task waits for the falling edge, applies the ID slot and lets it settle.
  task automatic drive_a(input logic v, input logic [4:0] rd, input logic we, input logic ld,
                         input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used,
                         input logic fl);
    @(negedge clk);
    a_valid = v; a_rd = rd; a_we = we; a_ld = ld;
    a_src = {s1, s0}; a_used = used; a_flush = fl;
    #1;
  endtask

  task automatic drive_b(input logic v, input logic [4:0] rd, input logic we, input logic ld,
                         input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used);
    @(negedge clk);
    b_valid = v; b_rd = rd; b_we = we; b_ld = ld;
    b_src = {s1, s0}; b_used = used; b_flush = 1'b0;
    #1;
  endtask

  task automatic drive_c(input logic v, input logic [4:0] rd, input logic we,
                         input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [2:0] used);
    @(negedge clk);
    c_valid = v; c_rd = rd; c_we = we; c_ld = 1'b0;
    c_src = {s2, s1, s0}; c_used = used; c_flush = 1'b0;
    #1;
  endtask

  initial begin
    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    a_valid = 0; a_rd = 0; a_we = 0; a_ld = 0; a_src = 0; a_used = 0; a_flush = 0;
    b_valid = 0; b_rd = 0; b_we = 0; b_ld = 0; b_src = 0; b_used = 0; b_flush = 0;
    c_valid = 0; c_rd = 0; c_we = 0; c_ld = 0; c_src = 0; c_used = 0; c_flush = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    #1;
    check("rst_sel", 32'(a_sel), 32'h0);
    check("rst_stall", 32'(a_stall), 32'h0);
    check("rst_cnt", a_cnt, 32'h0);

    // ALU back-to-back: add $3 ; sub $4,$3,$5
    drive_a(1, 5'd3, 1, 0, 5'd1, 5'd2, 2'b11, 0);
    check("alu_first_sel", 32'(a_sel), 32'h0);
    drive_a(1, 5'd4, 1, 0, 5'd3, 5'd5, 2'b11, 0);
    check("alu_b2b_sel", 32'(a_sel), 32'h1);
    check("alu_b2b_stall", 32'(a_stall), 32'h0);

    // Priority: add $3 ; add $3 ; or $6,$3,$3 ; or $7,$3,$3 ; nop ; add $9,$3,$3
    drive_a(1, 5'd3, 1, 0, 5'd1, 5'd2, 2'b11, 0);
    drive_a(1, 5'd3, 1, 0, 5'd1, 5'd2, 2'b11, 0);
    drive_a(1, 5'd6, 1, 0, 5'd3, 5'd3, 2'b11, 0);
    check("prio_youngest", 32'(a_sel), 32'h5);
    drive_a(1, 5'd7, 1, 0, 5'd3, 5'd3, 2'b11, 0);
    check("prio_mem", 32'(a_sel), 32'hA);
    drive_a(0, 5'd0, 0, 0, 5'd3, 5'd3, 2'b11, 0);
    check("prio_wb", 32'(a_sel), 32'hF);
    drive_a(1, 5'd9, 1, 0, 5'd3, 5'd3, 2'b11, 0);
    check("prio_dropped", 32'(a_sel), 32'h0);

    // Load-use: lw $2 ; add $7,$2,$1
    drive_a(1, 5'd2, 1, 1, 5'd29, 5'd0, 2'b01, 0);
    check("lw_no_stall", 32'(a_stall), 32'h0);
    drive_a(1, 5'd7, 1, 0, 5'd2, 5'd1, 2'b11, 0);
    check("lu_stall", 32'(a_stall), 32'h1);
    check("lu_stall_sel", 32'(a_sel), 32'h0);
    check("lu_cnt0", a_cnt, 32'h0);
    drive_a(1, 5'd7, 1, 0, 5'd2, 5'd1, 2'b11, 0);
    check("lu_release", 32'(a_stall), 32'h0);
    check("lu_fwd_mem", 32'(a_sel), 32'h2);
    check("lu_cnt1", a_cnt, 32'h1);

    // Ignored sources: addi with rt matching but unused; read of $0 after lw $0
    drive_a(1, 5'd10, 1, 0, 5'd5, 5'd7, 2'b01, 0);
    check("unused_src_sel", 32'(a_sel), 32'h0);
    check("unused_src_stall", 32'(a_stall), 32'h0);
    drive_a(1, 5'd0, 1, 1, 5'd29, 5'd0, 2'b01, 0);
    drive_a(1, 5'd11, 1, 0, 5'd0, 5'd7, 2'b11, 0);
    check("zero_reg_sel", 32'(a_sel), 32'hC);
    check("zero_reg_stall", 32'(a_stall), 32'h0);

    // Flush during hazard: lw $2 ; add $8,$2,$2 flushed ; add $12,$8,$2
    drive_a(1, 5'd2, 1, 1, 5'd29, 5'd0, 2'b01, 0);
    drive_a(1, 5'd8, 1, 0, 5'd2, 5'd2, 2'b11, 1);
    check("flush_stall", 32'(a_stall), 32'h0);
    check("flush_sel", 32'(a_sel), 32'h0);
    drive_a(1, 5'd12, 1, 0, 5'd8, 5'd2, 2'b11, 0);
    check("flush_bubble_sel", 32'(a_sel), 32'h8);
    check("flush_cnt", a_cnt, 32'h1);

    // Reset in the middle of a load-use stall
    drive_a(1, 5'd3, 1, 1, 5'd29, 5'd0, 2'b01, 0);
    drive_a(1, 5'd13, 1, 0, 5'd3, 5'd3, 2'b11, 0);
    check("pre_rst_stall", 32'(a_stall), 32'h1);
    a_rst = 1'b1;
    drive_a(1, 5'd13, 1, 0, 5'd3, 5'd3, 2'b11, 0);
    a_rst = 1'b0;
    check("midrst_stall", 32'(a_stall), 32'h0);
    check("midrst_sel", 32'(a_sel), 32'h0);
    check("midrst_cnt", a_cnt, 32'h0);

    // LOAD_READY = 2: two-cycle load-use stall
    drive_b(1, 5'd2, 1, 1, 5'd29, 5'd0, 2'b01);
    drive_b(1, 5'd7, 1, 0, 5'd2, 5'd1, 2'b11);
    check("lr2_stall_c1", 32'(b_stall), 32'h1);
    drive_b(1, 5'd7, 1, 0, 5'd2, 5'd1, 2'b11);
    check("lr2_stall_c2", 32'(b_stall), 32'h1);
    check("lr2_sel_held", 32'(b_sel), 32'h0);
    drive_b(1, 5'd7, 1, 0, 5'd2, 5'd1, 2'b11);
    check("lr2_release", 32'(b_stall), 32'h0);
    check("lr2_fwd_wb", 32'(b_sel), 32'h3);
    check("lr2_cnt", b_cnt, 32'h2);

    // NSRC = 3, DEPTH = 4
    drive_c(1, 5'd3, 1, 5'd1, 5'd2, 5'd4, 3'b111);
    drive_c(1, 5'd3, 1, 5'd1, 5'd2, 5'd4, 3'b111);
    drive_c(1, 5'd6, 1, 5'd3, 5'd3, 5'd3, 3'b111);
    check("d4_youngest", 32'(c_sel), 32'(9'b001_001_001));
    drive_c(0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 3'b000);
    drive_c(0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 3'b000);
    drive_c(1, 5'd9, 1, 5'd3, 5'd6, 5'd3, 3'b111);
    check("d4_stage3", 32'(c_sel), 32'(9'b100_011_100));
    check("d4_stall", 32'(c_stall), 32'h0);
    drive_c(1, 5'd9, 1, 5'd3, 5'd6, 5'd3, 3'b111);
    check("d4_dropped", 32'(c_sel), 32'(9'b000_100_000));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
